fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the decode and immediate-extend logic. It owns the PC, issues in-order word requests to instruction memory and buffers returned words in a small FIFO. It presents a valid/ready instruction stream (instr, instr_pc) to decode and supports branch/jump redirects that flush in-flight work.

---
 rtl/fetch_pkg.sv | 39 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the fetch unit (optional feature macro: PREDECODE_IMMSRC_EN)
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
`ifdef PREDECODE_IMMSRC_EN
        immsrc_t     immsrc;
`endif
    } fifo_entry_t;

    // Immediate format selected purely from the opcode; unknown opcodes fall back to I-type.
    function automatic immsrc_t predecode_immsrc(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_ITYPE, OP_JALR: return IMM_I;
            OP_STORE:                   return IMM_S;
            OP_BRANCH:                  return IMM_B;
            OP_JAL:                     return IMM_J;
            default:                    return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for the in-flight PC queue and the instruction buffer
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fifo_entry_t
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping; flush empties the FIFO without touching storage.
    always_ff @(posedge clk_i) begin
        if (!resetn_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage; contents are don't-care until a push makes them visible.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited requests, redirect flush and optional PREDECODE_IMMSRC_EN
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef PREDECODE_IMMSRC_EN
    ,
    output logic [1:0]  immsrc
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] discard_d;
    logic          run_q;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          resp_keep;
    logic          pop;
    logic [31:0]   resp_pc;
    fifo_entry_t   wr_entry;
    fifo_entry_t   head;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Every in-flight request and every buffered word holds one credit, so the
    // instruction buffer can always absorb a returning response.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req    = run_q && !redirect && (credit_used < CREDIT_LIMIT);
    assign imem_addr   = pc_q;
    assign issue       = imem_req && imem_gnt;

    // Responses during a redirect, or while stale requests drain, never reach the buffer.
    assign resp_keep   = imem_rvalid && (discard_q == '0) && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;

    // Addresses of granted requests, consumed in order as responses return.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [31:0])
    ) u_pc_queue (
        .clk_i       (clk),
        .resetn_i    (reset),
        .push_i      (issue),
        .push_data_i (pc_q),
        .pop_i       (imem_rvalid),
        .flush_i     (1'b0),
        .head_o      (resp_pc),
        .count_o     (outstanding)
    );

    // Build the buffered entry from the returning word and its request address.
    always_comb begin
        wr_entry       = '0;
        wr_entry.instr = imem_rdata;
        wr_entry.pc    = resp_pc;
`ifdef PREDECODE_IMMSRC_EN
        wr_entry.immsrc = predecode_immsrc(imem_rdata[6:0]);
`endif
    end

    // Instruction buffer presented to decode; a redirect discards everything held.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fifo_entry_t)
    ) u_instr_buf (
        .clk_i       (clk),
        .resetn_i    (reset),
        .push_i      (resp_keep),
        .push_data_i (wr_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;
`ifdef PREDECODE_IMMSRC_EN
    assign immsrc      = instr_valid ? head.immsrc : IMM_I;
`endif

    // Next PC and count of stale responses still to be dropped.
    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (redirect) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            discard_d = outstanding - CW'(imem_rvalid);
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    // Architectural fetch state; run_q delays the first request until after reset release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
            run_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
            run_q     <= 1'b1;
        end
    end

endmodule
